regfile_wb_arbiter: RTL and testbench

Writeback arbiter and load scoreboard for the 16-entry x 16-bit register file. It shares the register file's single write port between the ALU writeback source and the memory-load writeback source using valid/ready handshakes, and registers the winning write for one cycle. It also tracks destination registers of in-flight loads and tells decode when an instruction must stall. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and load scoreboard for the 16x16 register file write port.
// Define WB_RR_EN for two-way round-robin arbitration; otherwise loads have fixed priority over ALU.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_rd,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        ld_issue,
    input  logic [3:0]  ld_rd,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic [3:0]  id_rd,
    input  logic        id_wr,
    output logic        hazard,
    output logic [15:0] busy,
    output logic        reg_write,
    output logic [3:0]  rd,
    output logic [15:0] rd_data
);

    logic        wr_vld_p1;
    logic [3:0]  wr_rd_p1;
    logic [15:0] wr_data_p1;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] busy_nxt;

`ifdef WB_RR_EN
    // prefer_alu=1 means the ALU lost the most recent conflict and wins the next one
    logic prefer_alu;
    logic conflict;

    assign conflict  = alu_valid & mem_valid;
    assign mem_ready = mem_valid & ~(alu_valid & prefer_alu);
    assign alu_ready = alu_valid & ~(mem_valid & ~prefer_alu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prefer_alu <= 1'b0;
        else if (conflict)
            prefer_alu <= ~prefer_alu;
    end
`else
    assign mem_ready = mem_valid;
    assign alu_ready = alu_valid & ~mem_valid;
`endif

    // Stage p0 -> p1: register the granted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_rd_p1   <= 4'd0;
            wr_data_p1 <= 16'd0;
        end else if (mem_ready) begin
            wr_vld_p1  <= (mem_rd != 4'd0);
            wr_rd_p1   <= mem_rd;
            wr_data_p1 <= mem_data;
        end else if (alu_ready) begin
            wr_vld_p1  <= (alu_rd != 4'd0);
            wr_rd_p1   <= alu_rd;
            wr_data_p1 <= alu_data;
        end else begin
            wr_vld_p1  <= 1'b0;
        end
    end

    assign reg_write = wr_vld_p1;
    assign rd        = wr_rd_p1;
    assign rd_data   = wr_data_p1;

    always_comb begin
        set_vec = 16'd0;
        clr_vec = 16'd0;
        if (ld_issue && ld_rd != 4'd0)
            set_vec[ld_rd] = 1'b1;
        if (mem_ready)
            clr_vec[mem_rd] = 1'b1;
        // set is applied after clear so a same-cycle issue to the same register wins
        busy_nxt    = (busy & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= 16'd0;
        else
            busy <= busy_nxt;
    end

    assign hazard = busy[id_rs1] | busy[id_rs2] | (id_wr & busy[id_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard testbench for regfile_wb_arbiter; follows WB_RR_EN when it is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, ld_issue, id_wr;
    logic [3:0]  alu_rd, mem_rd, ld_rd, id_rs1, id_rs2, id_rd;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, hazard, reg_write;
    logic [15:0] busy, rd_data;
    logic [3:0]  rd;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    logic [15:0] m_busy;
    logic [3:0]  m_rd;
    logic [15:0] m_data;
    logic        m_pref_alu;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wr(id_wr),
        .hazard(hazard), .busy(busy),
        .reg_write(reg_write), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        ld_issue = 0; ld_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_wr = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 16'd0;
        m_rd = 4'd0;
        m_data = 16'd0;
        m_pref_alu = 1'b0;
    endtask

    // One clock: check combinational outputs, predict the registered result, advance and compare.
    task automatic step();
        logic  g_mem, g_alu;
        logic [15:0] nb;
        wr_t   e, got;
        #1;
        g_mem = 1'b0;
        g_alu = 1'b0;
        if (mem_valid && alu_valid) begin
`ifdef WB_RR_EN
            if (m_pref_alu) g_alu = 1'b1; else g_mem = 1'b1;
            m_pref_alu = ~m_pref_alu;
`else
            g_mem = 1'b1;
`endif
        end else if (mem_valid) begin
            g_mem = 1'b1;
        end else if (alu_valid) begin
            g_alu = 1'b1;
        end
        check("mem_ready", 32'(mem_ready), 32'(g_mem));
        check("alu_ready", 32'(alu_ready), 32'(g_alu));
        check("hazard", 32'(hazard),
              32'(m_busy[id_rs1] | m_busy[id_rs2] | (id_wr & m_busy[id_rd])));
        e.we = 1'b0;
        if (g_mem) begin m_rd = mem_rd; m_data = mem_data; e.we = (mem_rd != 0); end
        if (g_alu) begin m_rd = alu_rd; m_data = alu_data; e.we = (alu_rd != 0); end
        e.rd = m_rd;
        e.data = m_data;
        exp_q.push_back(e);
        nb = m_busy;
        if (g_mem) nb[mem_rd] = 1'b0;
        if (ld_issue && ld_rd != 0) nb[ld_rd] = 1'b1;
        @(posedge clk);
        #1;
        m_busy = nb;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check("reg_write", 32'(reg_write), 32'(got.we));
            check("rd", 32'(rd), 32'(got.rd));
            check("rd_data", 32'(rd_data), 32'(got.data));
        end
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #23;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        #4 rst = 1'b0;

        // lone ALU write, then an idle cycle
        alu_valid = 1; alu_rd = 4'd3; alu_data = 16'h1234;
        step();
        check("alu_write_rd", 32'(rd), 32'd3);
        check("alu_write_data", 32'(rd_data), 32'h1234);
        idle_inputs();
        step();
        check("idle_no_write", 32'(reg_write), 32'd0);

        // write to r0 handshakes but never writes
        mem_valid = 1; mem_rd = 4'd0; mem_data = 16'hFFFF;
        step();
        check("r0_no_write", 32'(reg_write), 32'd0);
        idle_inputs();

        // four-cycle conflict
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 4'd1; alu_data = 16'hA000 + 16'(i);
            mem_valid = 1; mem_rd = 4'd2; mem_data = 16'hB000 + 16'(i);
            step();
`ifdef WB_RR_EN
            check("conflict_rr_rd", 32'(rd), (i % 2 == 0) ? 32'd2 : 32'd1);
`else
            check("conflict_fixed_rd", 32'(rd), 32'd2);
`endif
        end
        idle_inputs();
        step();

        // scoreboard set, hazard on rs2, then clear by load return
        ld_issue = 1; ld_rd = 4'd5;
        step();
        idle_inputs();
        id_rs2 = 4'd5;
        check("busy_r5", 32'(busy), 32'h0020);
        step();
        mem_valid = 1; mem_rd = 4'd5; mem_data = 16'h5555;
        step();
        idle_inputs();
        id_rs2 = 4'd5; id_rd = 4'd5; id_wr = 1;
        check("busy_cleared", 32'(busy), 32'h0000);
        step();

        // same-cycle set and clear on r7: set wins
        idle_inputs();
        ld_issue = 1; ld_rd = 4'd7;
        step();
        mem_valid = 1; mem_rd = 4'd7; mem_data = 16'h7777;
        step();
        idle_inputs();
        check("collision_busy", 32'(busy), 32'h0080);
        mem_valid = 1; mem_rd = 4'd7;
        step();
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 4'($urandom);
            alu_data  = 16'($urandom);
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 4'($urandom);
            mem_data  = 16'($urandom);
            ld_issue  = ($urandom_range(0, 3) == 0);
            ld_rd     = 4'($urandom);
            id_rs1    = 4'($urandom);
            id_rs2    = 4'($urandom);
            id_rd     = 4'($urandom);
            id_wr     = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        mem_valid = 1;
        for (int r = 1; r < 16; r++) begin
            mem_rd = 4'(r);
            step();
        end
        idle_inputs();
        step();

        // reset in the middle of traffic
        for (int r = 4; r < 8; r++) begin
            ld_issue = 1; ld_rd = 4'(r);
            step();
        end
        idle_inputs();
        alu_valid = 1; alu_rd = 4'd9; alu_data = 16'h9999;
        step();
        check("pre_rst_reg_write", 32'(reg_write), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'h00F0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_reg_write", 32'(reg_write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'h0000);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        idle_inputs();
        alu_valid = 1; alu_rd = 4'd1; alu_data = 16'h0101;
        mem_valid = 1; mem_rd = 4'd2; mem_data = 16'h0202;
        step();
        check("post_rst_first_conflict", 32'(rd), 32'd2);
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
